// File: rtl/ram_write_port_if.sv
// rtl/ram_write_port_if.sv - request and readback bundle for the switch-driven RAM write port
interface ram_write_port_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 4
);
   logic                  wr_req;
   logic                  clr_req;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [7:0]            seg;
   logic                  busy;
   logic                  wr_done;
   logic [3:0]            wr_count;

   modport master (
      output wr_req, clr_req, addr, data_in,
      input  rd_data, seg, busy, wr_done, wr_count
   );

   modport slave (
      input  wr_req, clr_req, addr, data_in,
      output rd_data, seg, busy, wr_done, wr_count
   );
endinterface

// File: rtl/ram_write_port.sv
// rtl/ram_write_port.sv - register-file RAM with edge-triggered write/clear FSM, registered read and hex display
module ram_write_port #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 4
) (
   input  logic            clk_2,
   input  logic            reset,
   ram_write_port_if.slave bus
);
   localparam int                    DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t                state_q, state_d;
   logic                  wr_q, clr_q;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] d_q, d_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [3:0]            wr_count_q, wr_count_d;
   logic                  wr_done_q, wr_done_d;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_wa;
   logic [DATA_WIDTH-1:0] mem_wd;
   logic                  wr_rise, clr_rise;
   logic [6:0]            hex;

   assign wr_rise  = bus.wr_req  & ~wr_q;
   assign clr_rise = bus.clr_req & ~clr_q;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      d_d        = d_q;
      cnt_d      = cnt_q;
      wr_count_d = wr_count_q;
      wr_done_d  = 1'b0;
      mem_we     = 1'b0;
      mem_wa     = a_q;
      mem_wd     = d_q;
      unique case (state_q)
         IDLE: begin
            // clear has priority; a write edge in the same cycle is lost
            if (clr_rise) begin
               cnt_d   = '0;
               state_d = CLEAR;
            end else if (wr_rise) begin
               a_d     = bus.addr;
               d_d     = bus.data_in;
               state_d = WRITE;
            end
         end
         WRITE: begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + 4'd1;
            wr_done_d  = 1'b1;
            state_d    = IDLE;
         end
         CLEAR: begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
            cnt_d  = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST) begin
               wr_count_d = '0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_q       <= 1'b0;
         clr_q      <= 1'b0;
         a_q        <= '0;
         d_q        <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         wr_count_q <= '0;
         wr_done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wr_q       <= bus.wr_req;
         clr_q      <= bus.clr_req;
         a_q        <= a_d;
         d_q        <= d_d;
         cnt_q      <= cnt_d;
         wr_count_q <= wr_count_d;
         wr_done_q  <= wr_done_d;
         // read sees the contents from before this edge's write
         rd_data_q  <= mem_q[bus.addr];
         if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
         end
      end
   end

   always_comb begin
      hex = 7'h00;
      unique case (rd_data_q[3:0])
         4'h0: hex = 7'h3F;
         4'h1: hex = 7'h06;
         4'h2: hex = 7'h5B;
         4'h3: hex = 7'h4F;
         4'h4: hex = 7'h66;
         4'h5: hex = 7'h6D;
         4'h6: hex = 7'h7D;
         4'h7: hex = 7'h07;
         4'h8: hex = 7'h7F;
         4'h9: hex = 7'h6F;
         4'hA: hex = 7'h77;
         4'hB: hex = 7'h7C;
         4'hC: hex = 7'h39;
         4'hD: hex = 7'h5E;
         4'hE: hex = 7'h79;
         4'hF: hex = 7'h71;
         default: hex = 7'h00;
      endcase
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.seg      = {bus.busy, hex};
   assign bus.rd_data  = rd_data_q;
   assign bus.wr_done  = wr_done_q;
   assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_ram_write_port.sv
// tb/tb_ram_write_port.sv - bench for ram_write_port: schedule-based reference model plus directed and random stimulus
module tb_ram_write_port;
   localparam int AW    = 2;
   localparam int DW    = 4;
   localparam int DEPTH = 4;

   logic clk_2 = 1'b0;
   logic reset;

   ram_write_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   ram_write_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk_2 = ~clk_2;

   int checks     = 0;
   int failures   = 0;
   int done_seen  = 0;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Model: operations are scheduled by edge number rather than tracked as FSM states
   int         e         = 0;
   int         free_at   = 0;
   int         commit_at = -1;
   int         clr_at    = -100;
   logic [3:0] m_mem [DEPTH];
   logic [3:0] m_count, m_rd, p_d;
   logic [1:0] p_a;
   logic       m_done, m_busy, m_prev_wr, m_prev_clr;
   bit         m_valid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_count    = '0;
         m_done     = 1'b0;
         m_rd       = '0;
         m_busy     = 1'b0;
         m_prev_wr  = 1'b0;
         m_prev_clr = 1'b0;
         free_at    = e;
         commit_at  = -1;
         clr_at     = -100;
         m_valid    = 1;
      end else begin
         e++;
         m_rd   = m_mem[bus.addr];
         m_done = (e == commit_at);
         if (e == commit_at) begin
            m_mem[p_a] = p_d;
            m_count    = m_count + 4'd1;
         end
         if (e > clr_at && e <= clr_at + DEPTH) begin
            m_mem[e - clr_at - 1] = '0;
            if (e == clr_at + DEPTH) m_count = '0;
         end
         if (e > free_at) begin
            if (bus.clr_req && !m_prev_clr) begin
               clr_at  = e;
               free_at = e + DEPTH;
            end else if (bus.wr_req && !m_prev_wr) begin
               p_a       = bus.addr;
               p_d       = bus.data_in;
               commit_at = e + 1;
               free_at   = e + 1;
            end
         end
         m_busy     = (e < free_at);
         m_prev_wr  = bus.wr_req;
         m_prev_clr = bus.clr_req;
      end
   endtask

   initial forever begin
      @(posedge clk_2 or posedge reset);
      model_step();
   end

   initial forever begin
      @(negedge clk_2);
      if (m_valid) begin
         chk("rd_data",  32'(bus.rd_data),  32'(m_rd));
         chk("busy",     32'(bus.busy),     32'(m_busy));
         chk("wr_done",  32'(bus.wr_done),  32'(m_done));
         chk("wr_count", 32'(bus.wr_count), 32'(m_count));
         chk("seg",      32'(bus.seg),      32'({m_busy, seg_tab[m_rd]}));
         if (bus.wr_done === 1'b1) done_seen++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_2);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [3:0] d);
      bus.addr    = a;
      bus.data_in = d;
      bus.wr_req  = 1'b1;
      tick(1);
      bus.wr_req  = 1'b0;
      tick(2);
   endtask

   task automatic read_check(input string name, input logic [1:0] a,
                             input logic [3:0] exp_rd, input logic [7:0] exp_seg);
      bus.addr = a;
      tick(1);
      #1;
      chk({name, "_rd"},  32'(bus.rd_data), 32'(exp_rd));
      chk({name, "_seg"}, 32'(bus.seg),     32'(exp_seg));
   endtask

   initial begin
      int d0, bc, sc;
      reset       = 1'b1;
      bus.wr_req  = 1'b0;
      bus.clr_req = 1'b0;
      bus.addr    = 2'd2;
      bus.data_in = 4'd0;
      tick(3);
      #1;
      chk("rst_rd",    32'(bus.rd_data),  32'h0);
      chk("rst_seg",   32'(bus.seg),      32'h3F);
      chk("rst_busy",  32'(bus.busy),     32'h0);
      chk("rst_count", 32'(bus.wr_count), 32'h0);
      tick(1);
      reset = 1'b0;
      tick(1);

      d0 = done_seen;
      do_write(2'd0, 4'h6);
      do_write(2'd1, 4'hC);
      do_write(2'd2, 4'h9);
      do_write(2'd3, 4'h5);
      read_check("w0", 2'd0, 4'h6, 8'h7D);
      read_check("w1", 2'd1, 4'hC, 8'h39);
      read_check("w2", 2'd2, 4'h9, 8'h6F);
      read_check("w3", 2'd3, 4'h5, 8'h6D);
      chk("four_count", 32'(bus.wr_count), 32'd4);
      chk("four_done",  32'(done_seen - d0), 32'd4);
      chk("model_mem1", 32'(m_mem[1]), 32'hC);

      d0 = done_seen;
      bus.addr    = 2'd1;
      bus.data_in = 4'hA;
      bus.wr_req  = 1'b1;
      tick(1);
      bus.data_in = 4'h3;
      tick(9);
      bus.wr_req  = 1'b0;
      tick(2);
      chk("hold_count", 32'(bus.wr_count), 32'd5);
      chk("hold_done",  32'(done_seen - d0), 32'd1);
      read_check("hold", 2'd1, 4'hA, 8'h77);

      d0 = done_seen;
      bc = 0;
      sc = 0;
      bus.clr_req = 1'b1;
      bus.wr_req  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (bus.busy === 1'b1) bc++;
         if (bus.seg[7] === 1'b1) sc++;
      end
      bus.clr_req = 1'b0;
      bus.wr_req  = 1'b0;
      chk("clr_busy_cycles", 32'(bc), 32'd4);
      chk("clr_seg7_cycles", 32'(sc), 32'd4);
      chk("clr_count", 32'(bus.wr_count), 32'd0);
      chk("clr_done",  32'(done_seen - d0), 32'd0);
      for (int a = 0; a < DEPTH; a++) read_check("clr", 2'(a), 4'h0, 8'h3F);

      do_write(2'd2, 4'h7);
      bus.clr_req = 1'b1;
      tick(1);
      bus.clr_req = 1'b0;
      bus.addr    = 2'd2;
      bus.data_in = 4'h9;
      bus.wr_req  = 1'b1;
      tick(6);
      bus.wr_req  = 1'b0;
      tick(2);
      chk("ign_count", 32'(bus.wr_count), 32'd0);
      read_check("ign", 2'd2, 4'h0, 8'h3F);

      #2 reset = 1'b1;
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 17; i++) do_write(2'(i % 4), 4'(i));
      chk("wrap_count", 32'(bus.wr_count), 32'd1);
      chk("model_wrap", 32'(m_count), 32'd1);

      for (int a = 0; a < DEPTH; a++) do_write(2'(a), 4'hF);
      read_check("preF", 2'd3, 4'hF, 8'h71);
      bus.clr_req = 1'b1;
      tick(1);
      bus.clr_req = 1'b0;
      tick(1);
      #2 reset = 1'b1;
      #1;
      chk("async_busy",  32'(bus.busy),     32'h0);
      chk("async_count", 32'(bus.wr_count), 32'h0);
      chk("async_seg",   32'(bus.seg),      32'h3F);
      tick(1);
      reset = 1'b0;
      for (int a = 0; a < DEPTH; a++) read_check("rstclr", 2'(a), 4'h0, 8'h3F);

      // random phase: sparse clears, frequent write toggles, occasional async reset
      for (int i = 0; i < 600; i++) begin
         bus.wr_req  = ($urandom_range(0, 2) == 0);
         bus.clr_req = ($urandom_range(0, 19) == 0);
         bus.addr    = 2'($urandom_range(0, 3));
         bus.data_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 149) == 0) begin
            #2 reset = 1'b1;
         end
         tick(1);
         reset = 1'b0;
      end
      bus.wr_req  = 1'b0;
      bus.clr_req = 1'b0;
      tick(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
